// File: rtl/width_conv_pkg.sv
// Shared types and width helpers for the wide-to-narrow width converter and its FIFO.
package width_conv_pkg;

    typedef enum logic {
        LANE_MSB_FIRST = 1'b0,
        LANE_LSB_FIRST = 1'b1
    } lane_order_e;

    // Index width that never collapses to zero bits.
    function automatic int unsigned clog2w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // FIFO entry layout: {data, last_lane, last}
    localparam int unsigned ENTRY_LAST_W = 1;

    function automatic int unsigned entry_w(input int unsigned in_w, input int unsigned out_w);
        return in_w + clog2w(in_w / out_w) + ENTRY_LAST_W;
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO: the head entry is visible on rdata
// the cycle after it is written, with a registered occupancy count.
module sync_fifo_fwft #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       push,
    input  logic [W-1:0]               wdata,
    input  logic                       pop,
    output logic [W-1:0]               rdata,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          flush;
    logic          do_push;
    logic          do_pop;

    assign flush   = rst || clr;
    assign full    = (level_q == (AW+1)'(DEPTH));
    assign empty   = (level_q == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + (AW+1)'(1);
            2'b01:   level_d = level_q - (AW+1)'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign level = level_q;

endmodule

// File: rtl/width_down_buffer.sv
// Buffered wide-to-narrow converter: wide words queue in a FWFT FIFO and are
// emitted one lane per accepted output beat, honouring a per-word last lane.
module width_down_buffer
    import width_conv_pkg::*;
#(
    parameter int unsigned IN_W      = 512,
    parameter int unsigned OUT_W     = 64,
    parameter int unsigned DEPTH     = 256,
    parameter bit          LSB_FIRST = 1'b1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              clr,
    input  logic [IN_W-1:0]                   in_data,
    input  logic [$clog2(IN_W/OUT_W)-1:0]     in_last_lane,
    input  logic                              in_last,
    input  logic                              in_valid,
    output logic                              in_ready,
    output logic [OUT_W-1:0]                  out_data,
    output logic                              out_last,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [$clog2(DEPTH):0]            level,
    output logic                              full,
    output logic                              empty
);

    localparam int unsigned RATIO = IN_W / OUT_W;
    localparam int unsigned LW    = $clog2(RATIO);
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned EW    = entry_w(IN_W, OUT_W);
    localparam int unsigned NSLOT = 2 ** LW;
    localparam lane_order_e ORDER = LSB_FIRST ? LANE_LSB_FIRST : LANE_MSB_FIRST;

    if ((IN_W % OUT_W) != 0 || RATIO < 2) begin : g_bad_ratio
        $error("width_down_buffer: IN_W must be a multiple of OUT_W with ratio >= 2");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("width_down_buffer: DEPTH must be a power of two >= 2");
    end

    logic [EW-1:0]    fifo_wdata;
    logic [EW-1:0]    fifo_rdata;
    logic [AW:0]      fifo_level;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_push;
    logic             fifo_pop;

    logic [IN_W-1:0]  head_data;
    logic [LW-1:0]    head_last_lane;
    logic             head_last;
    logic [LW-1:0]    eff_last;
    logic             at_last;
    logic             beat;

    logic [LW-1:0]    sel_q, sel_d;
    logic [LW-1:0]    phys_sel;
    logic [OUT_W-1:0] lane_mux [NSLOT];

    assign fifo_wdata = {in_data, in_last_lane, in_last};
    assign fifo_push  = in_valid && !fifo_full;
    assign fifo_pop   = beat && at_last;

    sync_fifo_fwft #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .push  (fifo_push),
        .wdata (fifo_wdata),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .level (fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign head_data      = fifo_rdata[EW-1 -: IN_W];
    assign head_last_lane = fifo_rdata[LW:1];
    assign head_last      = fifo_rdata[0];

    // Clamp so a last_lane beyond the word for non-power-of-two ratios still ends the word.
    assign eff_last = (head_last_lane > LW'(RATIO - 1)) ? LW'(RATIO - 1) : head_last_lane;
    assign at_last  = (sel_q == eff_last);
    assign beat     = !fifo_empty && out_ready;

    genvar gi;
    for (gi = 0; gi < NSLOT; gi++) begin : g_lane
        if (gi < RATIO) begin : g_used
            assign lane_mux[gi] = head_data[gi*OUT_W +: OUT_W];
        end else begin : g_pad
            assign lane_mux[gi] = '0;
        end
    end

    always_comb begin
        phys_sel = sel_q;
        if (ORDER == LANE_MSB_FIRST) begin
            phys_sel = LW'(RATIO - 1) - sel_q;
        end
    end

    always_comb begin
        sel_d = sel_q;
        if (beat) begin
            sel_d = at_last ? '0 : sel_q + LW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            sel_q <= '0;
        end else begin
            sel_q <= sel_d;
        end
    end

    assign in_ready  = !fifo_full;
    assign out_valid = !fifo_empty;
    assign out_data  = fifo_empty ? '0 : lane_mux[phys_sel];
    assign out_last  = !fifo_empty && head_last && at_last;
    assign level     = fifo_level;
    assign full      = fifo_full;
    assign empty     = fifo_empty;

endmodule

// File: tb/tb_width_down_buffer.sv
// Scoreboard bench: two converters (LSB-first and MSB-first) share stimulus; expected
// beats are queued at push time and a negedge monitor checks every accepted beat.
module tb_width_down_buffer;

    localparam int IN_W  = 512;
    localparam int OUT_W = 64;
    localparam int DEPTH = 8;
    localparam int RATIO = 8;
    localparam int LW    = 3;
    localparam int AW    = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              clr = 1'b0;
    logic [IN_W-1:0]   in_data = '0;
    logic [LW-1:0]     in_last_lane = '0;
    logic              in_last = 1'b0;
    logic              in_valid = 1'b0;
    logic              out_ready = 1'b0;

    logic              a_in_ready, b_in_ready;
    logic [OUT_W-1:0]  a_out_data, b_out_data;
    logic              a_out_last, b_out_last;
    logic              a_out_valid, b_out_valid;
    logic [AW:0]       a_level, b_level;
    logic              a_full, b_full, a_empty, b_empty;

    always #5 clk = ~clk;

    width_down_buffer #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .LSB_FIRST(1'b1)) u_dut (
        .clk(clk), .rst(rst), .clr(clr), .in_data(in_data), .in_last_lane(in_last_lane),
        .in_last(in_last), .in_valid(in_valid), .in_ready(a_in_ready), .out_data(a_out_data),
        .out_last(a_out_last), .out_valid(a_out_valid), .out_ready(out_ready),
        .level(a_level), .full(a_full), .empty(a_empty)
    );

    width_down_buffer #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .LSB_FIRST(1'b0)) u_dut_msb (
        .clk(clk), .rst(rst), .clr(clr), .in_data(in_data), .in_last_lane(in_last_lane),
        .in_last(in_last), .in_valid(in_valid), .in_ready(b_in_ready), .out_data(b_out_data),
        .out_last(b_out_last), .out_valid(b_out_valid), .out_ready(out_ready),
        .level(b_level), .full(b_full), .empty(b_empty)
    );

    typedef struct {
        logic [63:0] d;
        logic        l;
        logic        we;
    } beat_t;

    beat_t       qa[$];
    beat_t       qb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          lvl_m = 0;
    bit          stall_m = 1'b0;
    logic [63:0] prev_a = '0;
    logic [63:0] prev_b = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: model occupancy, check status each cycle and every accepted beat.
    always @(negedge clk) begin
        if (rst || clr) begin
            qa.delete();
            qb.delete();
            lvl_m   = 0;
            stall_m = 1'b0;
        end else begin
            bit    vm;
            bit    pushm;
            bit    popm;
            beat_t ea;
            beat_t eb;
            vm   = (lvl_m != 0);
            popm = 1'b0;
            chk("level",       64'(a_level),     64'(lvl_m));
            chk("level_msb",   64'(b_level),     64'(lvl_m));
            chk("empty",       64'(a_empty),     64'(lvl_m == 0));
            chk("full",        64'(a_full),      64'(lvl_m == DEPTH));
            chk("in_ready",    64'(a_in_ready),  64'(lvl_m < DEPTH));
            chk("out_valid",   64'(a_out_valid), 64'(vm));
            chk("out_valid_b", 64'(b_out_valid), 64'(vm));
            if (!vm) begin
                chk("idle_data", a_out_data, 64'd0);
                chk("idle_last", 64'(a_out_last), 64'd0);
            end
            if (stall_m) begin
                chk("stall_data",   a_out_data, prev_a);
                chk("stall_data_b", b_out_data, prev_b);
            end
            if (vm && out_ready) begin
                if (qa.size() == 0 || qb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL beat: got unexpected beat %0h, scoreboard empty", a_out_data);
                end else begin
                    ea = qa.pop_front();
                    eb = qb.pop_front();
                    $display("beat lsb=%0h msb=%0h last=%0b/%0b", a_out_data, b_out_data, a_out_last, b_out_last);
                    chk("beat_data",     a_out_data,        ea.d);
                    chk("beat_last",     64'(a_out_last),   64'(ea.l));
                    chk("beat_data_msb", b_out_data,        eb.d);
                    chk("beat_last_msb", 64'(b_out_last),   64'(eb.l));
                    popm = ea.we;
                end
            end
            pushm   = in_valid && (lvl_m < DEPTH);
            stall_m = vm && !out_ready;
            prev_a  = a_out_data;
            prev_b  = b_out_data;
            lvl_m   = lvl_m + int'(pushm) - int'(popm);
        end
    end

    function automatic logic [IN_W-1:0] mk_word(input int base);
        logic [IN_W-1:0] w;
        for (int k = 0; k < RATIO; k++) begin
            w[k*OUT_W +: OUT_W] = 64'(base + k);
        end
        return w;
    endfunction

    // Drives one word for one cycle; the expected lanes are queued only when it will be accepted.
    task automatic push_word(input logic [IN_W-1:0] d, input logic [LW-1:0] ll,
                             input logic lst, input bit accept);
        if (accept) begin
            for (int s = 0; s <= int'(ll); s++) begin
                beat_t ea;
                beat_t eb;
                ea.d  = d[s*OUT_W +: OUT_W];
                eb.d  = d[(RATIO-1-s)*OUT_W +: OUT_W];
                ea.l  = lst && (s == int'(ll));
                ea.we = (s == int'(ll));
                eb.l  = ea.l;
                eb.we = ea.we;
                qa.push_back(ea);
                qb.push_back(eb);
            end
        end
        in_data      = d;
        in_last_lane = ll;
        in_last      = lst;
        in_valid     = 1'b1;
        @(posedge clk);
        #1;
        in_valid     = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain(input int budget);
        int c;
        c = 0;
        out_ready = 1'b1;
        while ((lvl_m != 0 || qa.size() != 0) && c < budget) begin
            @(posedge clk);
            #1;
            c++;
        end
        n_cmp++;
        if (c >= budget) begin
            n_bad++;
            $display("FAIL drain: got %0d words left, expected 0 within %0d cycles", lvl_m, budget);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [LW-1:0] lls [6];
        lls = '{3'd7, 3'd3, 3'd0, 3'd5, 3'd1, 3'd7};

        idle(3);
        rst = 1'b0;
        chk("rst_out_data",  a_out_data,         64'd0);
        chk("rst_out_last",  64'(a_out_last),    64'd0);
        chk("rst_out_valid", 64'(a_out_valid),   64'd0);
        chk("rst_empty",     64'(a_empty),       64'd1);
        chk("rst_full",      64'(a_full),        64'd0);
        chk("rst_in_ready",  64'(a_in_ready),    64'd1);
        chk("rst_level",     64'(a_level),       64'd0);

        // Full words, with and without packet end: LSB gives 0..7, MSB gives 7..0.
        out_ready = 1'b1;
        push_word(mk_word(0), 3'd7, 1'b1, 1'b1);
        drain(50);
        push_word(mk_word(16), 3'd7, 1'b0, 1'b1);
        drain(50);

        // Partial word: three beats only.
        push_word(mk_word(32), 3'd2, 1'b1, 1'b1);
        drain(50);

        // Fill to DEPTH, extra push refused, one word drained clears full.
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            push_word(mk_word(64 + 8*i), 3'd1, 1'(i == DEPTH-1), 1'b1);
        end
        chk("fill_full",     64'(a_full),     64'd1);
        chk("fill_in_ready", 64'(a_in_ready), 64'd0);
        chk("fill_level",    64'(a_level),    64'(DEPTH));
        push_word(mk_word(200), 3'd7, 1'b1, 1'b0);
        chk("extra_level",   64'(a_level),    64'(DEPTH));
        out_ready = 1'b1;
        idle(2);
        out_ready = 1'b0;
        chk("unfull_full",  64'(a_full),  64'd0);
        chk("unfull_level", 64'(a_level), 64'(DEPTH-1));
        drain(100);

        // Back-to-back pushes with random output stalls.
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    push_word(mk_word(400 + 16*i), lls[i], 1'(i % 2), 1'b1);
                end
            end
            begin
                repeat (60) begin
                    out_ready = 1'($urandom_range(0, 1));
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        drain(200);

        // Flush in the middle of a word.
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push_word(mk_word(600 + 8*i), 3'd7, 1'b1, 1'b1);
        end
        out_ready = 1'b1;
        idle(3);
        out_ready = 1'b0;
        chk("pre_clr_level", 64'(a_level), 64'd5);
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        chk("clr_level",     64'(a_level),     64'd0);
        chk("clr_empty",     64'(a_empty),     64'd1);
        chk("clr_out_valid", 64'(a_out_valid), 64'd0);
        push_word(mk_word(800), 3'd7, 1'b1, 1'b1);
        drain(50);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
